// File: rtl/dcache_pkg.sv
// Shared types and geometry for the L1 data cache controller.
// Tag entries are laid out as {valid, dirty, tag}.
package dcache_pkg;

    localparam int INDEX_W = 4;
    localparam int OFFS_W  = 5;
    localparam int TAG_W   = 32 - INDEX_W - OFFS_W;
    localparam int LINE_W  = 8 << OFFS_W;
    localparam int ENTRY_W = TAG_W + 2;
    localparam int WORD_W  = OFFS_W - 2;

    localparam int VALID_BIT = TAG_W + 1;
    localparam int DIRTY_BIT = TAG_W;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        REFILL,
        FILL
    } state_t;

endpackage

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache sequencer.
// Hits finish in IDLE; misses walk WB -> REFILL -> FILL -> IDLE.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_wdata_i,
    output logic [31:0]        cpu_rdata_o,
    output logic               cpu_stall_o,
    output logic [INDEX_W-1:0] sram_idx_o,
    output logic               sram_we_o,
    output logic [ENTRY_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]  sram_data_o,
    input  logic [ENTRY_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]  sram_data_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    input  logic               mem_ack_i,
    input  logic [LINE_W-1:0]  mem_data_i
);

    state_t state, state_n;

    logic [LINE_W-1:0]  line_buf;
    logic [LINE_W-1:0]  merged;
    logic [INDEX_W-1:0] idx;
    logic [WORD_W-1:0]  word;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   vic_tag;
    logic               vic_valid;
    logic               vic_dirty;
    logic               hit;
    logic [7:0]         bit_pos;
    logic               unused_ok;

    assign idx       = cpu_addr_i[OFFS_W+INDEX_W-1:OFFS_W];
    assign word      = cpu_addr_i[OFFS_W-1:2];
    assign req_tag   = cpu_addr_i[31-:TAG_W];
    assign vic_tag   = sram_tag_i[TAG_W-1:0];
    assign vic_valid = sram_tag_i[VALID_BIT];
    assign vic_dirty = sram_tag_i[DIRTY_BIT];
    assign hit       = vic_valid && (vic_tag == req_tag);
    assign bit_pos   = {word, 5'd0};
    assign unused_ok = ^cpu_addr_i[1:0];

    always_comb begin
        merged = sram_data_i;
        merged[bit_pos+:32] = cpu_wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            line_buf <= '0;
        end else if (state == REFILL && mem_ack_i) begin
            line_buf <= mem_data_i;
        end
    end

    // Outputs are gated by reset so an in-flight request drops at once.
    always_comb begin
        state_n     = state;
        cpu_rdata_o = '0;
        cpu_stall_o = 1'b0;
        sram_idx_o  = '0;
        sram_we_o   = 1'b0;
        sram_tag_o  = '0;
        sram_data_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        if (rst_i) begin
            sram_idx_o = idx;
            unique case (state)
                IDLE: begin
                    if (cpu_req_i && hit) begin
                        if (cpu_we_i) begin
                            sram_we_o   = 1'b1;
                            sram_tag_o  = {2'b11, req_tag};
                            sram_data_o = merged;
                        end else begin
                            cpu_rdata_o = sram_data_i[bit_pos+:32];
                        end
                    end else if (cpu_req_i) begin
                        cpu_stall_o = 1'b1;
                        state_n = (vic_valid && vic_dirty) ? WB : REFILL;
                    end
                end
                WB: begin
                    cpu_stall_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = {vic_tag, idx, {OFFS_W{1'b0}}};
                    mem_data_o  = sram_data_i;
                    if (mem_ack_i) begin
                        state_n = REFILL;
                    end
                end
                REFILL: begin
                    cpu_stall_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_addr_o  = {req_tag, idx, {OFFS_W{1'b0}}};
                    if (mem_ack_i) begin
                        state_n = FILL;
                    end
                end
                FILL: begin
                    cpu_stall_o = 1'b1;
                    sram_we_o   = 1'b1;
                    sram_tag_o  = {2'b10, req_tag};
                    sram_data_o = line_buf;
                    state_n     = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: SRAM and memory models, directed
// vectors, back-to-back hits, reset abort and randomized traffic.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               cpu_req_i = 1'b0;
    logic               cpu_we_i = 1'b0;
    logic [31:0]        cpu_addr_i = '0;
    logic [31:0]        cpu_wdata_i = '0;
    logic [31:0]        cpu_rdata_o;
    logic               cpu_stall_o;
    logic [INDEX_W-1:0] sram_idx_o;
    logic               sram_we_o;
    logic [ENTRY_W-1:0] sram_tag_o;
    logic [LINE_W-1:0]  sram_data_o;
    logic [ENTRY_W-1:0] sram_tag_i;
    logic [LINE_W-1:0]  sram_data_i;
    logic               mem_req_o;
    logic               mem_we_o;
    logic [31:0]        mem_addr_o;
    logic [LINE_W-1:0]  mem_data_o;
    logic               mem_ack_i = 1'b0;
    logic [LINE_W-1:0]  mem_data_i = '0;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .sram_idx_o  (sram_idx_o),
        .sram_we_o   (sram_we_o),
        .sram_tag_o  (sram_tag_o),
        .sram_data_o (sram_data_o),
        .sram_tag_i  (sram_tag_i),
        .sram_data_i (sram_data_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i)
    );

    // External tag+data array with combinational read
    logic [ENTRY_W-1:0] tag_arr [16];
    logic [LINE_W-1:0]  data_arr [16];
    logic               sram_clr = 1'b1;
    logic               poke_en = 1'b0;
    logic [INDEX_W-1:0] poke_idx = '0;
    logic [ENTRY_W-1:0] poke_val = '0;

    assign sram_tag_i  = tag_arr[sram_idx_o];
    assign sram_data_i = data_arr[sram_idx_o];

    always @(posedge clk_i) begin
        if (sram_clr) begin
            for (int i = 0; i < 16; i++) begin
                tag_arr[i]  <= '0;
                data_arr[i] <= '0;
            end
        end else if (poke_en) begin
            tag_arr[poke_idx] <= poke_val;
        end else if (sram_we_o) begin
            tag_arr[sram_idx_o]  <= sram_tag_o;
            data_arr[sram_idx_o] <= sram_data_o;
        end
    end

    function automatic logic [31:0] word_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [LINE_W-1:0] line_init(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32+:32] = word_init(la + 32'(w * 4));
        end
        return l;
    endfunction

    // Off-chip memory: ack after a chosen number of request cycles.
    // mem_mode: 0 normal, 1 never ack, 2 stray acks every other cycle
    logic [LINE_W-1:0] mem_line [logic [31:0]];
    int                mem_mode = 0;
    int                fixed_delay = 0;
    int                cnt = 0;
    int                cur_delay = 1;
    int                wb_d = 0;
    int                rf_d = 0;
    logic [31:0]       mem_la;

    always begin
        @(negedge clk_i);
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
        end else if (mem_mode == 2) begin
            mem_ack_i = 1'b1;
        end
        if (!mem_req_o || !rst_i) begin
            cnt = 0;
        end else if (mem_mode == 0 && !mem_ack_i) begin
            cnt++;
            if (cnt == 1) begin
                cur_delay = (fixed_delay > 0) ? fixed_delay
                                              : int'($urandom_range(1, 4));
                if (mem_we_o) wb_d = cur_delay;
                else rf_d = cur_delay;
            end
            if (cnt == cur_delay) begin
                mem_ack_i = 1'b1;
                mem_la = mem_addr_o;
                if (mem_we_o) begin
                    mem_line[mem_la] = mem_data_o;
                end else if (mem_line.exists(mem_la)) begin
                    mem_data_i = mem_line[mem_la];
                end else begin
                    mem_data_i = line_init(mem_la);
                end
            end
        end
    end

    // Reference model: flat word memory plus cache bookkeeping
    logic [31:0] ref_mem [logic [31:0]];
    logic        rv [16];
    logic        rdty [16];
    logic [22:0] rt [16];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic ref_hit(input logic [31:0] a);
        return rv[a[8:5]] && rt[a[8:5]] == a[31:9];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return ref_mem.exists(k) ? ref_mem[k] : word_init(k);
    endfunction

    task automatic ref_update(input logic we, input logic [31:0] a,
                              input logic [31:0] wd);
        if (!ref_hit(a)) begin
            rv[a[8:5]] = 1'b1;
            rt[a[8:5]] = a[31:9];
            rdty[a[8:5]] = 1'b0;
        end
        if (we) begin
            rdty[a[8:5]] = 1'b1;
            ref_mem[{a[31:2], 2'b00}] = wd;
        end
    endtask

    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output int stalls,
                          output logic [31:0] rd, output logic wbs,
                          output logic [31:0] wba, output logic swe,
                          output logic [ENTRY_W-1:0] stag,
                          output logic [31:0] sword, output logic tmo);
        logic [7:0] bp;
        bp = {a[4:2], 5'd0};
        cpu_req_i = 1'b1;
        cpu_we_i = we;
        cpu_addr_i = a;
        cpu_wdata_i = wd;
        stalls = 0;
        wbs = 1'b0;
        wba = '0;
        tmo = 1'b0;
        while (!tmo) begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            stalls++;
            if (mem_req_o && mem_we_o) begin
                wbs = 1'b1;
                wba = mem_addr_o;
            end
            if (stalls > 200) tmo = 1'b1;
            else begin
                @(posedge clk_i);
                #1;
            end
        end
        rd = cpu_rdata_o;
        swe = sram_we_o;
        stag = sram_tag_o;
        sword = sram_data_o[bp+:32];
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          delay;
        int          stalls;
        logic        wb;
        logic [31:0] wba;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [6];

    int                 st;
    logic [31:0]        rd;
    logic               wbs;
    logic [31:0]        wba;
    logic               swe;
    logic [ENTRY_W-1:0] stag;
    logic [31:0]        sword;
    logic               tmo;

    task automatic ref_access(input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input string nm);
        logic        h;
        logic        ewb;
        logic [31:0] ewba;
        logic [31:0] erd;
        int          est;
        h = ref_hit(a);
        ewb = !h && rv[a[8:5]] && rdty[a[8:5]];
        ewba = {rt[a[8:5]], a[8:5], 5'd0};
        erd = ref_word(a);
        access(we, a, wd, st, rd, wbs, wba, swe, stag, sword, tmo);
        est = h ? 0 : 2 + rf_d + (ewb ? wb_d : 0);
        chk({nm, " timeout"}, 64'(tmo), 64'(0));
        chk({nm, " stalls"}, 64'(st), 64'(est));
        chk({nm, " wb"}, 64'(wbs), 64'(ewb));
        if (ewb) chk({nm, " wb addr"}, 64'(wba), 64'(ewba));
        if (we) begin
            chk({nm, " st we"}, 64'(swe), 64'(1));
            chk({nm, " st tag"}, 64'(stag), 64'({2'b11, a[31:9]}));
            chk({nm, " st word"}, 64'(sword), 64'(wd));
        end else begin
            chk({nm, " rdata"}, 64'(rd), 64'(erd));
        end
        ref_update(we, a, wd);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rv[i] = 1'b0;
            rdty[i] = 1'b0;
            rt[i] = '0;
        end
        tbl[0] = '{1'b0, 32'h40, 32'h0, 10, 12, 1'b0, 32'h0,
                   word_init(32'h40)};
        tbl[1] = '{1'b1, 32'h44, 32'hDEADBEEF, 1, 0, 1'b0, 32'h0,
                   32'h0};
        tbl[2] = '{1'b0, 32'h240, 32'h0, 3, 8, 1'b1, 32'h40,
                   word_init(32'h240)};
        tbl[3] = '{1'b0, 32'h44, 32'h0, 2, 4, 1'b0, 32'h0,
                   32'hDEADBEEF};
        tbl[4] = '{1'b0, 32'h40, 32'h0, 1, 0, 1'b0, 32'h0,
                   word_init(32'h40)};
        tbl[5] = '{1'b0, 32'hAAE0, 32'h0, 2, 4, 1'b0, 32'h0,
                   word_init(32'hAAE0)};

        // Reset with a pending miss request: everything must stay quiet
        cpu_req_i = 1'b1;
        cpu_addr_i = 32'h40;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        sram_clr = 1'b0;
        poke_en = 1'b1;
        poke_idx = 4'd7;
        poke_val = {2'b01, 23'd5};
        @(posedge clk_i);
        #1;
        poke_en = 1'b0;
        @(negedge clk_i);
        chk("rst stall", 64'(cpu_stall_o), 64'(0));
        chk("rst mem_req", 64'(mem_req_o), 64'(0));
        chk("rst mem_we", 64'(mem_we_o), 64'(0));
        chk("rst sram_we", 64'(sram_we_o), 64'(0));
        chk("rst mem_addr", 64'(mem_addr_o), 64'(0));
        chk("rst sram_idx", 64'(sram_idx_o), 64'(0));
        chk("rst rdata", 64'(cpu_rdata_o), 64'(0));
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            fixed_delay = tbl[i].delay;
            access(tbl[i].we, tbl[i].addr, tbl[i].wd, st, rd, wbs, wba,
                   swe, stag, sword, tmo);
            chk({nm, " timeout"}, 64'(tmo), 64'(0));
            chk({nm, " stalls"}, 64'(st), 64'(tbl[i].stalls));
            chk({nm, " wb"}, 64'(wbs), 64'(tbl[i].wb));
            if (tbl[i].wb) chk({nm, " wb addr"}, 64'(wba),
                               64'(tbl[i].wba));
            if (tbl[i].we) begin
                chk({nm, " st we"}, 64'(swe), 64'(1));
                chk({nm, " st tag"}, 64'(stag),
                    64'({2'b11, tbl[i].addr[31:9]}));
                chk({nm, " st word"}, 64'(sword), 64'(tbl[i].wd));
            end else begin
                chk({nm, " rdata"}, 64'(rd), 64'(tbl[i].rdata));
            end
            ref_update(tbl[i].we, tbl[i].addr, tbl[i].wd);
        end
        fixed_delay = 0;

        // Warm every line, then one hit per cycle with no stall
        for (int i = 0; i < 16; i++) begin
            ref_access(1'b0, 32'(i << 5), 32'h0, "warm");
        end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [31:0] wd;
            a = 32'((i << 5) | 12);
            wd = $urandom;
            cpu_req_i = 1'b1;
            cpu_we_i = i[0];
            cpu_addr_i = a;
            cpu_wdata_i = wd;
            @(negedge clk_i);
            chk("b2b stall", 64'(cpu_stall_o), 64'(0));
            if (i[0]) chk("b2b st we", 64'(sram_we_o), 64'(1));
            else chk("b2b rdata", 64'(cpu_rdata_o), 64'(ref_word(a)));
            ref_update(i[0], a, wd);
            @(posedge clk_i);
            #1;
        end
        cpu_req_i = 1'b0;

        // Reset while REFILL waits for an ack that never comes
        mem_mode = 1;
        cpu_req_i = 1'b1;
        cpu_we_i = 1'b0;
        cpu_addr_i = 32'h1280;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("abort stall", 64'(cpu_stall_o), 64'(1));
        chk("abort req", 64'(mem_req_o), 64'(1));
        chk("abort we", 64'(mem_we_o), 64'(0));
        chk("abort addr", 64'(mem_addr_o), 64'(32'h1280));
        #2;
        rst_i = 1'b0;
        #1;
        chk("abort rst req", 64'(mem_req_o), 64'(0));
        chk("abort rst stall", 64'(cpu_stall_o), 64'(0));
        chk("abort rst sram_we", 64'(sram_we_o), 64'(0));
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        mem_mode = 2;
        repeat (6) begin
            @(negedge clk_i);
            chk("stray ack stall", 64'(cpu_stall_o), 64'(0));
            chk("stray ack req", 64'(mem_req_o), 64'(0));
            chk("stray ack sram_we", 64'(sram_we_o), 64'(0));
        end
        mem_mode = 0;
        repeat (2) @(posedge clk_i);
        #1;
        ref_access(1'b0, 32'h80, 32'h0, "post abort");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {21'(0), 2'($urandom_range(0, 3)), 4'($urandom),
                 3'($urandom), 2'b00};
            ref_access(1'($urandom), a, $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
